// File: rtl/perspective_divide_viewport_if.sv
// Handshake and data bundle between the vertex transform, the perspective
// divide / viewport stage, and the rasteriser that consumes its results.
interface perspective_divide_viewport_if #(
   parameter int WIDTH = 32
);
   logic                    i_valid;
   logic                    o_ready;
   logic signed [WIDTH-1:0] i_x;
   logic signed [WIDTH-1:0] i_y;
   logic signed [WIDTH-1:0] i_z;
   logic signed [WIDTH-1:0] i_w;
   logic [15:0]             i_viewport_width;
   logic [15:0]             i_viewport_height;
   logic                    o_valid;
   logic                    i_ready;
   logic signed [WIDTH-1:0] o_screen_x;
   logic signed [WIDTH-1:0] o_screen_y;
   logic signed [WIDTH-1:0] o_depth;
   logic                    o_clipped;

   // Stage side: consumes vertices, produces screen-space results
   modport slave (
      input  i_valid, i_x, i_y, i_z, i_w, i_viewport_width, i_viewport_height, i_ready,
      output o_ready, o_valid, o_screen_x, o_screen_y, o_depth, o_clipped
   );

   // Environment side: supplies vertices and accepts results
   modport master (
      output i_valid, i_x, i_y, i_z, i_w, i_viewport_width, i_viewport_height, i_ready,
      input  o_ready, o_valid, o_screen_x, o_screen_y, o_depth, o_clipped
   );
endinterface

// File: rtl/perspective_divide_viewport.sv
// Perspective divide and viewport mapping for one clip-space vertex at a time.
// 1/w is produced by a bit-serial restoring divider, then a single scale cycle
// turns NDC into pixel coordinates and a [0,1] depth.
module perspective_divide_viewport #(
   parameter int WIDTH = 32,
   parameter int FRAC  = 16
) (
   input logic                          i_clk,
   input logic                          i_reset,
   perspective_divide_viewport_if.slave bus
);

   localparam int QW = 2*FRAC + 1;
   localparam int CW = $clog2(QW + 1);
   localparam int EW = (QW > WIDTH) ? QW : WIDTH;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_DIVIDE = 2'd1;
   localparam logic [1:0] S_SCALE  = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;

   localparam logic signed [WIDTH-1:0] ONE     = WIDTH'(1) << FRAC;
   localparam logic        [WIDTH-1:0] MAXPOS  = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic        [EW-1:0]    MAXPOSE = EW'(MAXPOS);

   logic [1:0]              r_state;
   logic signed [WIDTH-1:0] r_x, r_y, r_z, r_w;
   logic [15:0]             r_vp_width, r_vp_height;
   logic [QW-1:0]           r_dividend;
   logic [QW-1:0]           r_quot;
   logic [WIDTH-1:0]        r_rem;
   logic [CW-1:0]           r_count;
   logic signed [WIDTH-1:0] r_screen_x, r_screen_y, r_depth;
   logic                    r_clipped;

   logic                      w_clip;
   logic [WIDTH:0]            w_rem_shift;
   logic [WIDTH:0]            w_rem_sub;
   logic                      w_ge;
   logic [EW-1:0]             w_quot_ext;
   logic signed [WIDTH-1:0]   w_recip;
   logic signed [2*WIDTH-1:0] w_prod_x, w_prod_y, w_prod_z, w_prod_sx, w_prod_sy;
   logic signed [WIDTH-1:0]   w_ndc_x, w_ndc_y, w_ndc_z;
   logic signed [WIDTH-1:0]   w_half_w, w_half_h;
   logic signed [WIDTH-1:0]   w_sx_in, w_sy_in, w_depth_sum;
   logic signed [WIDTH-1:0]   w_screen_x, w_screen_y, w_depth;

   assign bus.o_ready    = (r_state == S_IDLE) && !i_reset;
   assign bus.o_valid    = (r_state == S_DONE);
   assign bus.o_screen_x = r_screen_x;
   assign bus.o_screen_y = r_screen_y;
   assign bus.o_depth    = r_depth;
   assign bus.o_clipped  = r_clipped;

   // A vertex with w <= 0 is behind the eye and is rejected outright
   assign w_clip = bus.i_w[WIDTH-1] || (bus.i_w == '0);

   // One restoring-division step plus saturation of the finished quotient to the largest positive word
   always_comb begin
      w_rem_shift = {r_rem, r_dividend[QW-1]};
      w_ge        = (w_rem_shift >= {1'b0, r_w});
      w_rem_sub   = w_rem_shift - {1'b0, r_w};
      w_quot_ext  = EW'(r_quot);
      w_recip     = (w_quot_ext > MAXPOSE) ? MAXPOS : WIDTH'(w_quot_ext);
   end

   // Scale-cycle arithmetic: NDC via the reciprocal, then viewport mapping with y flipped to point down
   always_comb begin
      w_prod_x    = r_x * w_recip;
      w_prod_y    = r_y * w_recip;
      w_prod_z    = r_z * w_recip;
      w_ndc_x     = WIDTH'(w_prod_x >>> FRAC);
      w_ndc_y     = WIDTH'(w_prod_y >>> FRAC);
      w_ndc_z     = WIDTH'(w_prod_z >>> FRAC);
      w_half_w    = WIDTH'(r_vp_width) << (FRAC - 1);
      w_half_h    = WIDTH'(r_vp_height) << (FRAC - 1);
      w_sx_in     = w_ndc_x + ONE;
      w_sy_in     = ONE - w_ndc_y;
      w_prod_sx   = w_sx_in * w_half_w;
      w_prod_sy   = w_sy_in * w_half_h;
      w_screen_x  = WIDTH'(w_prod_sx >>> FRAC);
      w_screen_y  = WIDTH'(w_prod_sy >>> FRAC);
      w_depth_sum = w_ndc_z + ONE;
      w_depth     = w_depth_sum >>> 1;
   end

   // Control FSM: accept, iterate the divider one quotient bit per cycle, scale, then hold the result until taken
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state     <= S_IDLE;
         r_x         <= '0;
         r_y         <= '0;
         r_z         <= '0;
         r_w         <= '0;
         r_vp_width  <= '0;
         r_vp_height <= '0;
         r_dividend  <= '0;
         r_quot      <= '0;
         r_rem       <= '0;
         r_count     <= '0;
         r_screen_x  <= '0;
         r_screen_y  <= '0;
         r_depth     <= '0;
         r_clipped   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.i_valid) begin
                  r_x         <= bus.i_x;
                  r_y         <= bus.i_y;
                  r_z         <= bus.i_z;
                  r_w         <= bus.i_w;
                  r_vp_width  <= bus.i_viewport_width;
                  r_vp_height <= bus.i_viewport_height;
                  r_dividend  <= {1'b1, {(QW-1){1'b0}}};
                  r_quot      <= '0;
                  r_rem       <= '0;
                  r_count     <= '0;
                  if (w_clip) begin
                     r_clipped  <= 1'b1;
                     r_screen_x <= '0;
                     r_screen_y <= '0;
                     r_depth    <= '0;
                     r_state    <= S_DONE;
                  end else begin
                     r_clipped  <= 1'b0;
                     r_state    <= S_DIVIDE;
                  end
               end
            end
            S_DIVIDE: begin
               r_rem      <= w_ge ? w_rem_sub[WIDTH-1:0] : w_rem_shift[WIDTH-1:0];
               r_quot     <= {r_quot[QW-2:0], w_ge};
               r_dividend <= {r_dividend[QW-2:0], 1'b0};
               r_count    <= r_count + 1'b1;
               if (r_count == CW'(QW - 1)) begin
                  r_state <= S_SCALE;
               end
            end
            S_SCALE: begin
               r_screen_x <= w_screen_x;
               r_screen_y <= w_screen_y;
               r_depth    <= w_depth;
               r_state    <= S_DONE;
            end
            S_DONE: begin
               if (bus.i_ready) begin
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_perspective_divide_viewport.sv
// Testbench for perspective_divide_viewport: directed vertices with known
// screen positions, clipping, backpressure, mid-divide reset, and a randomized
// stream scored against an arithmetic reference model.
module tb_perspective_divide_viewport;

   logic clk = 1'b0;
   logic rst;
   int   testsRun  = 0;
   int   failCount = 0;

   typedef struct {
      int sx;
      int sy;
      int d;
      bit clip;
   } result_t;

   result_t expQ[$];

   perspective_divide_viewport_if #(.WIDTH(32)) bus ();

   perspective_divide_viewport #(.WIDTH(32), .FRAC(16)) dut (
      .i_clk   (clk),
      .i_reset (rst),
      .bus     (bus)
   );

   // Free-running clock, 10 time units per cycle
   always #5 clk = ~clk;

   // Watchdog so the run can never hang
   initial begin
      #400000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic int fmul(input int a, input int b);
      longint p;
      p = longint'(a) * longint'(b);
      return int'(p >>> 16);
   endfunction

   // Reference: real-number style divide and viewport map in Q16.16 integers
   function automatic result_t model(input int x, input int y, input int z, input int w,
                                     input int vw, input int vh);
      result_t r;
      longint  recip;
      int      one;
      int      ndcX, ndcY, ndcZ;
      r.sx = 0; r.sy = 0; r.d = 0; r.clip = 1'b0;
      if (w <= 0) begin
         r.clip = 1'b1;
         return r;
      end
      one   = 65536;
      recip = (longint'(1) << 32) / longint'(w);
      if (recip > longint'(2147483647)) recip = 2147483647;
      ndcX = fmul(x, int'(recip));
      ndcY = fmul(y, int'(recip));
      ndcZ = fmul(z, int'(recip));
      r.sx = fmul(ndcX + one, vw * 32768);
      r.sy = fmul(one - ndcY, vh * 32768);
      r.d  = (ndcZ + one) >>> 1;
      return r;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      testsRun++;
      if (got !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Present a vertex, wait for the handshake edge, then scramble the inputs
   task automatic applyStimulus(input int x, input int y, input int z, input int w,
                                input logic [15:0] vw, input logic [15:0] vh);
      int n;
      n = 0;
      bus.i_valid = 1'b1;
      bus.i_x = x; bus.i_y = y; bus.i_z = z; bus.i_w = w;
      bus.i_viewport_width = vw; bus.i_viewport_height = vh;
      while (!bus.o_ready && n < 1000) begin
         @(negedge clk);
         n++;
      end
      if (!bus.o_ready) checkOutput("acceptTimeout", 32'(bus.o_ready), 32'd1);
      @(negedge clk);
      bus.i_valid = 1'b0;
      bus.i_x = $urandom; bus.i_y = $urandom; bus.i_z = $urandom; bus.i_w = $urandom;
      bus.i_viewport_width = 16'($urandom); bus.i_viewport_height = 16'($urandom);
   endtask

   task automatic runVertex(input string name, input int x, input int y, input int z, input int w,
                            input logic [15:0] vw, input logic [15:0] vh, input int hold,
                            output int sx, output int sy, output int d, output bit clip);
      result_t e;
      int      n;
      int      expLat;
      bit      readySeen;
      bit      stable;
      e = model(x, y, z, w, vw, vh);
      expLat = e.clip ? 1 : 35;
      bus.i_ready = (hold == 0);
      applyStimulus(x, y, z, w, vw, vh);
      n = 1;
      readySeen = 1'b0;
      while (!bus.o_valid && n < 200) begin
         if (bus.o_ready) readySeen = 1'b1;
         @(negedge clk);
         n++;
      end
      checkOutput({name, ".valid"},    32'(bus.o_valid), 32'd1);
      checkOutput({name, ".latency"},  n, expLat);
      checkOutput({name, ".readyLow"}, 32'(readySeen), 32'd0);
      checkOutput({name, ".sx"},       bus.o_screen_x, e.sx);
      checkOutput({name, ".sy"},       bus.o_screen_y, e.sy);
      checkOutput({name, ".depth"},    bus.o_depth, e.d);
      checkOutput({name, ".clipped"},  32'(bus.o_clipped), 32'(e.clip));
      sx = bus.o_screen_x;
      sy = bus.o_screen_y;
      d  = bus.o_depth;
      clip = bus.o_clipped;
      if (hold > 0) begin
         stable = 1'b1;
         for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            if (!bus.o_valid || bus.o_ready || bus.o_screen_x !== sx || bus.o_screen_y !== sy ||
                bus.o_depth !== d || bus.o_clipped !== clip) stable = 1'b0;
         end
         checkOutput({name, ".bpStable"}, 32'(stable), 32'd1);
         bus.i_ready = 1'b1;
      end
      @(negedge clk);
      checkOutput({name, ".released"}, {30'd0, bus.o_valid, bus.o_ready}, 32'd1);
   endtask

   initial begin
      int sx, sy, d;
      bit clip;
      localparam int N = 24;

      rst = 1'b1;
      bus.i_valid = 1'b0; bus.i_ready = 1'b1;
      bus.i_x = '0; bus.i_y = '0; bus.i_z = '0; bus.i_w = '0;
      bus.i_viewport_width = '0; bus.i_viewport_height = '0;
      repeat (3) @(negedge clk);
      checkOutput("rst.ready", 32'(bus.o_ready), 32'd0);
      checkOutput("rst.valid", 32'(bus.o_valid), 32'd0);
      checkOutput("rst.sx", bus.o_screen_x, 32'd0);
      checkOutput("rst.sy", bus.o_screen_y, 32'd0);
      checkOutput("rst.depth", bus.o_depth, 32'd0);
      checkOutput("rst.clipped", 32'(bus.o_clipped), 32'd0);
      rst = 1'b0;
      #1;
      checkOutput("rst.readyAfter", 32'(bus.o_ready), 32'd1);

      runVertex("centre", 0, 0, 0, 32'h00010000, 16'd640, 16'd480, 0, sx, sy, d, clip);
      checkOutput("centre.sxConst", sx, 32'h01400000);
      checkOutput("centre.syConst", sy, 32'h00F00000);
      checkOutput("centre.dConst",  d,  32'h00008000);

      runVertex("corner", 32'h00020000, -32'sh00020000, 32'h00020000, 32'h00020000,
                16'd640, 16'd480, 0, sx, sy, d, clip);
      checkOutput("corner.sxConst", sx, 32'h02800000);
      checkOutput("corner.syConst", sy, 32'h01E00000);
      checkOutput("corner.dConst",  d,  32'h00010000);

      runVertex("fracW", 32'h00004000, 0, 0, 32'h00008000, 16'd640, 16'd480, 0, sx, sy, d, clip);
      checkOutput("fracW.sxConst", sx, 32'h01E00000);
      checkOutput("fracW.syConst", sy, 32'h00F00000);
      checkOutput("fracW.dConst",  d,  32'h00008000);

      runVertex("clipZero", 32'h00010000, 32'h00010000, 32'h00010000, 0,
                16'd640, 16'd480, 0, sx, sy, d, clip);
      checkOutput("clipZero.flag", 32'(clip), 32'd1);
      runVertex("clipNeg", 32'h00010000, 32'h00010000, 32'h00010000, -32'sh00010000,
                16'd640, 16'd480, 0, sx, sy, d, clip);
      checkOutput("clipNeg.flag", 32'(clip), 32'd1);

      runVertex("backpressure", 32'h00018000, 32'h00008000, -32'sh00004000, 32'h00020000,
                16'd640, 16'd480, 5, sx, sy, d, clip);

      runVertex("satRecip", 32'h00000003, -32'sh00000002, 32'h00000001, 32'h00000001,
                16'd800, 16'd600, 0, sx, sy, d, clip);

      // Abort an operation part-way through the divide
      bus.i_ready = 1'b1;
      applyStimulus(32'h00010000, 32'h00010000, 32'h00010000, 32'h00030000, 16'd640, 16'd480);
      repeat (9) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("midRst.valid", 32'(bus.o_valid), 32'd0);
      checkOutput("midRst.sx", bus.o_screen_x, 32'd0);
      checkOutput("midRst.sy", bus.o_screen_y, 32'd0);
      checkOutput("midRst.depth", bus.o_depth, 32'd0);
      checkOutput("midRst.ready", 32'(bus.o_ready), 32'd0);
      rst = 1'b0;
      #1;
      checkOutput("midRst.readyAfter", 32'(bus.o_ready), 32'd1);
      runVertex("afterRst", -32'sh00008000, 32'h00004000, 32'h00008000, 32'h00010000,
                16'd1920, 16'd1080, 0, sx, sy, d, clip);

      // Randomized stream with random backpressure, scored in order
      fork
         begin
            for (int i = 0; i < N; i++) begin
               int x, y, z, w;
               logic [15:0] vw, vh;
               case ($urandom_range(0, 3))
                  0:       w = int'($urandom_range(1, 32'h00FFFFFF));
                  1:       w = int'($urandom_range(1, 256));
                  2:       w = -int'($urandom_range(0, 32'h00FFFFFF));
                  default: w = int'($urandom_range(32'h00008000, 32'h00040000));
               endcase
               x  = int'($urandom_range(0, 32'h0007FFFF)) - 32'sh00040000;
               y  = int'($urandom_range(0, 32'h0007FFFF)) - 32'sh00040000;
               z  = int'($urandom_range(0, 32'h0007FFFF)) - 32'sh00040000;
               vw = 16'($urandom_range(1, 4096));
               vh = 16'($urandom_range(1, 4096));
               expQ.push_back(model(x, y, z, w, vw, vh));
               applyStimulus(x, y, z, w, vw, vh);
            end
         end
         begin
            int got;
            int cyc;
            result_t e;
            got = 0;
            cyc = 0;
            while (got < N && cyc < 8000) begin
               @(negedge clk);
               cyc++;
               bus.i_ready = 1'($urandom_range(0, 1));
               if (bus.o_valid && bus.i_ready) begin
                  if (expQ.size() == 0) begin
                     checkOutput("rnd.unexpected", 32'd1, 32'd0);
                  end else begin
                     e = expQ.pop_front();
                     checkOutput("rnd.sx", bus.o_screen_x, e.sx);
                     checkOutput("rnd.sy", bus.o_screen_y, e.sy);
                     checkOutput("rnd.depth", bus.o_depth, e.d);
                     checkOutput("rnd.clipped", 32'(bus.o_clipped), 32'(e.clip));
                  end
                  got++;
               end
            end
            checkOutput("rnd.delivered", got, N);
         end
      join

      bus.i_ready = 1'b1;
      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end

endmodule

// File: doc/perspective_divide_viewport.md
# perspective_divide_viewport

Sequential stage directly downstream of the matrix-vertex transform. Takes a clip-space vertex (x, y, z, w) and performs the perspective divide with an iterative reciprocal of w. Maps the result to screen-space pixel coordinates plus a normalised depth, ready for the rasteriser. Uses a valid/ready handshake on both sides and processes one vertex at a time.

## Interface
- WIDTH, 32: fixed-point word width (signed, two's complement).
- FRAC, 16: fractional bits (Q(WIDTH-FRAC).FRAC).
- i_clk  in  1  clock; all state updates on rising edge.
- i_reset  in  1  reset, synchronous, active-high.
- i_valid  in  1  input vertex valid.
- o_ready  out  1  stage can accept a vertex.
- i_x, i_y, i_z, i_w  in  WIDTH each  clip-space vertex, signed fixed-point.
- i_viewport_width, i_viewport_height  in  16 each  unsigned integer pixels; sampled on accept.
- o_valid  out  1  result valid.
- i_ready  in  1  downstream accepts result.
- o_screen_x, o_screen_y  out  WIDTH each  signed fixed-point pixel coordinates.
- o_depth  out  WIDTH  signed fixed-point, 0.0 = near, 1.0 = far.
- o_clipped  out  1  vertex rejected (w <= 0).

## Operation
- FSM states: IDLE, DIVIDE, SCALE, DONE.
- Reset: state IDLE; o_valid=0, o_clipped=0, o_screen_x/o_screen_y/o_depth=0, all internal registers 0. o_ready=0 while i_reset is high.
- IDLE: o_ready=1. On i_valid && o_ready, latch x, y, z, w and the viewport dims.
  - w <= 0 (signed): go to DONE with o_clipped=1, outputs 0.
  - Otherwise: go to DIVIDE with o_clipped=0.
- DIVIDE: unsigned restoring division computing recip = floor(2^(2*FRAC) / w).
  - Dividend is 2*FRAC+1 bits, one quotient bit per cycle, exactly 2*FRAC+1 cycles.
  - Quotient above 2^(WIDTH-1)-1 saturates to 2^(WIDTH-1)-1.
  - Then go to SCALE.
- SCALE (1 cycle):
  - Fixed-point multiply fmul(a,b) = (a*b) >>> FRAC. Full 2*WIDTH-bit product, arithmetic shift (rounds toward -inf), truncated to WIDTH.
  - ndc_x = fmul(x, recip); ndc_y and ndc_z likewise.
  - half_w = width << (FRAC-1); half_h = height << (FRAC-1).
  - one = 1 << FRAC.
  - screen_x = fmul(ndc_x + one, half_w).
  - screen_y = fmul(one - ndc_y, half_h) (y axis points down).
  - depth = (ndc_z + one) >>> 1.
  - No saturation on the SCALE arithmetic; WIDTH-bit wrap.
  - Register the results into outputs, then go to DONE.
- DONE: o_valid=1, outputs stable. On i_ready go to IDLE and drop o_valid.
- o_ready is 0 in DIVIDE, SCALE and DONE. There is no accept in the same cycle as the output transfer.
- Input fields are ignored outside the accept cycle. Changes to i_x etc. mid-operation have no effect.
- i_reset in any state aborts the operation. Next cycle is IDLE with reset values and no o_valid pulse.

## Timing
- Accept at cycle T (handshake edge).
- Non-clipped: DIVIDE T+1..T+2*FRAC+1, SCALE T+2*FRAC+2, o_valid high from T+2*FRAC+3 (T+35 with defaults).
- Clipped: o_valid high from T+1.
- o_valid stays high until the first edge with i_ready=1. o_ready returns the following cycle.
- Throughput with i_ready tied high: one vertex per 2*FRAC+4 cycles (36 with defaults).
- Outputs are registered; no combinational path from inputs to outputs. o_ready depends only on state and i_reset.

## Test plan
Defaults (WIDTH=32, FRAC=16), viewport 640x480, i_ready=1 unless stated.
- **Centre vertex:** (0, 0, 0, 1.0) -> o_screen_x=320.0 (0x01400000), o_screen_y=240.0 (0x00F00000), o_depth=0x00008000, o_clipped=0, o_valid exactly 35 cycles after accept.
- **Corner vertex:** (2.0, -2.0, 2.0, 2.0) -> ndc (1, -1, 1); o_screen_x=640.0, o_screen_y=480.0, o_depth=0x00010000.
- **Fractional w:** w=0.5 (0x8000), x=0.25 -> recip=0x00020000, o_screen_x=480.0; y=z=0 -> o_screen_y=240.0, o_depth=0.5.
- **Clip:** w=0 and w=-1.0 each -> o_clipped=1, all outputs 0, o_valid one cycle after accept.
- **Backpressure:** hold i_ready low for 5 cycles after o_valid rises -> outputs and o_valid stable, o_ready=0 throughout. Release -> o_ready=1 next cycle. Back-to-back i_valid vertices are both delivered in order, none lost.
- **Reset mid-divide:** assert i_reset 10 cycles after accept -> next cycle o_valid=0, outputs 0, o_ready=1 after reset drops. A new vertex then completes with correct values.
